// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_added.sv
// One-bit full adder cell, shared across every bit position of the serial add.
module full_added (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder cell sequenced LSB-first, one bit per clock,
// with valid/ready handshakes on both the operand and the result side.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  sum_sh;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic              fa_sum;
    logic              fa_c;
    logic              last_bit;

    full_added u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .sum   (fa_sum),
        .c_out (fa_c)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready only in IDLE, out_valid only in DONE, never together.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                    // The visible result only updates once the MSB is done, so
                    // outputs keep the previous answer while a new add runs.
                    if (last_bit) begin
                        sum   <= {fa_sum, sum_sh[WIDTH-1:1]};
                        c_out <= fa_c;
                        ovf   <= carry ^ fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed cases plus random operands against an
// arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W+1:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference: {c_out, ovf, sum} from plain integer arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                           input logic ci);
        int   u;
        int   s;
        logic co;
        logic ov;
        u  = int'(ai) + int'(bi) + int'(ci);
        s  = int'($signed(ai)) + int'($signed(bi)) + int'(ci);
        co = (u >= (1 << W));
        ov = (s > ((1 << (W - 1)) - 1)) || (s < -(1 << (W - 1)));
        return {co, ov, W'(u)};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_timeout", 32'(n < 100), 32'd1);
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_result(input string tag, input logic [W+1:0] e);
        check({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
        check({tag, "_cout"}, 32'(c_out), 32'(e[W+1]));
        check({tag, "_ovf"}, 32'(ovf), 32'(e[W]));
    endtask

    // driver: one full transaction with optional backpressure and a spurious request
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                         input int hold, input bit spur);
        int n;
        logic [W+1:0] e;
        exp_q.push_back(model(ai, bi, ci));
        out_ready = (hold == 0);
        a = ai; b = bi; c_in = ci; in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
        check("run_flags", 32'({busy, in_ready, out_valid}), 32'(3'b100));
        n = 0;
        while (!out_valid && n < 50) begin
            if (spur && n == 3) begin
                in_valid = 1'b1;
                a = 8'h11;
            end
            @(posedge clk); #1;
            n++;
            if (!out_valid) check("run_in_ready", 32'(in_ready), 32'd0);
        end
        check("latency", 32'(n), 32'(W));
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        for (int i = 0; i < hold; i++) begin
            check("hold_flags", 32'({out_valid, in_ready, busy}), 32'(3'b101));
            check_result("hold", e);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("done_flags", 32'({out_valid, in_ready, busy}), 32'(3'b101));
        check_result("result", e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_handshake", 32'({out_valid, in_ready, busy}), 32'(3'b010));
        if (spur) begin
            @(posedge clk); #1;
            check("spurious_ignored", 32'({busy, out_valid}), 32'd0);
        end
    endtask

    initial begin
        int n;
        int acc0;
        int acc1;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
        #2;
        check("reset_flags", 32'({out_valid, busy, in_ready}), 32'd0);
        check("reset_result", 32'({c_out, ovf, sum}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        do_op(8'h0F, 8'h01, 1'b0, 0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
        do_op(8'hAA, 8'h55, 1'b1, 5, 1'b1);

        // reset in the middle of RUN
        a = 8'h3C; b = 8'h0F; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_flags", 32'({out_valid, busy, in_ready}), 32'd0);
        check("midrun_rst_result", 32'({c_out, ovf, sum}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("no_result_after_rst", 32'({out_valid, busy}), 32'd0);
        end
        do_op(8'h3C, 8'h0F, 1'b0, 0, 1'b0);

        // back-to-back with in_valid held high
        out_ready = 1'b1;
        a = 8'h80; b = 8'h80; c_in = 1'b0; in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        acc0 = cyc;
        a = 8'h01; b = 8'h02;
        wait_out_valid(n);
        check("b2b_latency0", 32'(n), 32'(W));
        check_result("b2b_0", model(8'h80, 8'h80, 1'b0));
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        acc1 = cyc;
        in_valid = 1'b0;
        check("b2b_accepted", 32'(busy), 32'd1);
        check("b2b_interval", 32'(acc1 - acc0), 32'(W + 2));
        wait_out_valid(n);
        check("b2b_latency1", 32'(n), 32'(W));
        check_result("b2b_1", model(8'h01, 8'h02, 1'b0));
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then sequences a single one-bit full adder cell LSB-first, one bit per clock. It returns the WIDTH-bit sum, carry-out and signed-overflow flag over a second valid/ready handshake. Its purpose is to share one full adder across an arbitrary operand width, trading latency for area.

Parameters:
- WIDTH, default 8, operand/sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  controller can accept operands.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in for the addition.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result bits a+b+c_in, modulo 2^WIDTH.
- c_out  out  1  unsigned carry-out of the MSB.
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB).
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; out_valid=0; sum=0; c_out=0; ovf=0; busy=0; carry register=0; bit counter=0.
- in_ready is 0 while rst is high.
- States:
  - IDLE: in_ready=1.
    - If in_valid is high at a rising edge, the operands are accepted at that edge.
    - On acceptance: latch a and b into shift registers, load the carry register with c_in, clear the counter, go to RUN.
  - RUN: in_ready=0, busy=1. Every edge:
    - The full adder is driven with a_sh[0], b_sh[0] and the carry register.
    - Its sum bit is shifted into the MSB of the sum shift register (right shift).
    - The carry register takes the adder's carry out; a_sh and b_sh shift right; the counter increments.
    - At the edge where the counter equals WIDTH-1, also capture ovf = carry register XOR adder carry out, capture c_out = adder carry out, and go to DONE.
  - DONE: out_valid=1, busy=1, in_ready=0.
    - sum, c_out and ovf are held stable until out_valid && out_ready.
    - On that handshake edge: go to IDLE and clear out_valid.
- Latency: out_valid rises exactly WIDTH edges after the acceptance edge. Minimum initiation interval is WIDTH+2 cycles.
- No overlap:
  - in_valid is ignored outside IDLE.
  - in_ready rises the cycle after the output handshake, never in the same cycle.
- out_ready may be held high permanently; DONE then lasts exactly one cycle.
- Outputs sum, c_out and ovf are registered. Their values are undefined-but-stable outside DONE; the implementation holds the last result.
- Reset mid-operation: the operation is discarded, all registers return to their reset values, and no result is produced.
- Counter width is $clog2(WIDTH). There is no wrap-around inside RUN because the exit happens at WIDTH-1.
- Operand changes on a and b after acceptance have no effect.

Decomposition:
- Package serial_add_pkg holds:
  - the state typedef (enum of IDLE, RUN, DONE, 2 bits);
  - the default WIDTH localparam.
- One sub-module: the existing one-bit full adder cell full_added (a, b, c_in -> sum, c_out). It is instantiated once; all sequencing lives in serial_add_ctrl.

Test Plan:
1. WIDTH=8; a=8'h0F, b=8'h01, c_in=0, out_ready=1 -> sum=8'h10, c_out=0, ovf=0; out_valid exactly 8 edges after acceptance, high for 1 cycle.
2. a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1, ovf=0.
3. a=8'h7F, b=8'h01, c_in=0 -> sum=8'h80, c_out=0, ovf=1.
4. Backpressure: a=8'hAA, b=8'h55, c_in=1 with out_ready=0 for 5 cycles after out_valid, and in_valid pulsed with a=8'h11 during RUN/DONE:
   - in_ready stays 0 throughout;
   - the new request is ignored;
   - sum=8'h00, c_out=1, ovf=0 held stable until out_ready=1;
   - in_ready returns 1 on the following cycle.
5. Reset mid-RUN: assert rst asynchronously after 3 bits of a=8'h3C + b=8'h0F -> out_valid, sum, c_out, ovf and busy are 0 immediately. After release, a fresh a=8'h3C + b=8'h0F, c_in=0 gives sum=8'h4B, c_out=0.
6. Back-to-back with in_valid held high and out_ready=1, a=8'h80 + b=8'h80, then a=8'h01 + b=8'h02:
   - results are sum=8'h00, c_out=1, ovf=1, then sum=8'h03, c_out=0, ovf=0;
   - acceptance edges are 10 cycles apart.
